// File: rtl/router_pkt_reader.sv
// rtl/router_pkt_reader.sv - drains router_fifo through a 2-entry skid buffer, parses header/payload/parity, flushes on stall timeout
module router_pkt_reader #(
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [1:0] pkt_addr,
    output logic [5:0] pkt_len,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       soft_reset
);

    localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_HDR, S_BODY, S_PAR} state_t;

    state_t        state_q, state_d;
    logic [5:0]    rem_q, rem_d;
    logic [7:0]    par_q, par_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [9:0]    ent0_q, ent0_d, ent1_q, ent1_d;
    logic          inflight_q, inflight_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          block_q, block_d;
    logic [1:0]    addr_q, addr_d;
    logic [5:0]    len_q, len_d;
    logic          done_q, done_d;
    logic          perr_q, perr_d;

    logic          pop, push, stall;
    logic [2:0]    occ;
    logic [9:0]    new_ent;

    assign pkt_addr   = addr_q;
    assign pkt_len    = len_q;
    assign pkt_done   = done_q;
    assign parity_err = perr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_HDR;
            rem_q      <= '0;
            par_q      <= '0;
            cnt_q      <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            inflight_q <= 1'b0;
            stall_q    <= '0;
            block_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            block_q    <= block_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        out_valid  = (cnt_q != 2'd0);
        out_data   = out_valid ? ent0_q[7:0] : 8'h00;
        out_last   = out_valid & ent0_q[8];
        pop        = out_valid & out_ready;
        stall      = out_valid & ~out_ready;
        soft_reset = stall && (stall_q == SW'(TIMEOUT - 1));
        push       = inflight_q & ~soft_reset;
        occ        = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
        // Reset gates the strobe combinationally so it drops in the same cycle as the async clear.
        fifo_rd_en = ~reset & ~fifo_empty & ~soft_reset & ~block_q & (occ < 3'd2);

        state_d    = state_q;
        rem_d      = rem_q;
        par_d      = par_q;
        addr_d     = addr_q;
        len_d      = len_q;
        new_ent    = {2'b00, fifo_dout};
        if (push) begin
            case (state_q)
                S_HDR: begin
                    addr_d  = fifo_dout[1:0];
                    len_d   = fifo_dout[7:2];
                    rem_d   = fifo_dout[7:2];
                    par_d   = fifo_dout;
                    state_d = (fifo_dout[7:2] != 6'd0) ? S_BODY : S_PAR;
                end
                S_BODY: begin
                    par_d = par_q ^ fifo_dout;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) state_d = S_PAR;
                end
                S_PAR: begin
                    new_ent = {(fifo_dout != par_q), 1'b1, fifo_dout};
                    state_d = S_HDR;
                end
                default: state_d = S_HDR;
            endcase
        end

        // Shift out on pop first, then append the returned byte behind whatever remains.
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (pop) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (push && cnt_d != 2'd2) begin
            if (cnt_d == 2'd0) ent0_d = new_ent;
            else               ent1_d = new_ent;
            cnt_d = cnt_d + 2'd1;
        end

        stall_d    = stall ? stall_q + SW'(1) : '0;
        inflight_d = fifo_rd_en;
        block_d    = soft_reset;
        done_d     = pop & ent0_q[8];
        perr_d     = pop & ent0_q[8] & ent0_q[9];

        if (soft_reset) begin
            cnt_d   = 2'd0;
            stall_d = '0;
            state_d = S_HDR;
        end
    end

endmodule
